// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning: turns raw rs1/rs2 into magnitudes plus the flags
// that say whether the final product/quotient and remainder must be negated.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic             neg_result,
  output logic             neg_rem
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (funct3[2]) begin
      // DIV/REM are signed, DIVU/REMU are not
      a_signed = ~funct3[0];
      b_signed = ~funct3[0];
    end else begin
      a_signed = (funct3 != FUNCT3_MULHU);
      b_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH);
    end
  end

  assign a_neg      = a_signed & op_a[WIDTH-1];
  assign b_neg      = b_signed & op_b[WIDTH-1];
  assign a_mag      = a_neg ? -op_a : op_a;
  assign b_mag      = b_neg ? -op_b : op_b;
  assign neg_result = a_neg ^ b_neg;
  assign neg_rem    = a_neg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle. Optional macro MULDIV_EARLY_OUT_EN skips the
// iteration for divide-by-zero, signed overflow and multiply-by-zero.
//
//   state   | meaning
//   IDLE    | waiting for start, operands latched on accept
//   CALC    | one radix-2 step per cycle, WIDTH steps
//   DONE    | sign fix / special cases applied, done pulse, result registered
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               neg_result, neg_rem;
  logic               b_zero, ovf, early_out;

  logic [2:0]         funct3_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic               neg_res_q, neg_rem_q, b_zero_q, ovf_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   final_val;

  muldiv_operand_prep #(.WIDTH(WIDTH)) u_prep (
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .neg_result (neg_result),
    .neg_rem    (neg_rem)
  );

  assign b_zero = (op_b == '0);
  assign ovf    = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                  (op_a == SMIN) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = b_zero | ovf;
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = early_out ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Multiply: product's upper half accumulates b, whole register shifts right
  assign add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (prod_q[0] ? b_mag_q : {WIDTH{1'b0}})};
  assign mul_next = {add_sum, prod_q[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
  assign rem_ext  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign rem_sub  = rem_ext[WIDTH-1:0] - b_mag_q;
  assign div_next = (rem_ext >= {1'b0, b_mag_q}) ?
                    {rem_sub, prod_q[WIDTH-2:0], 1'b1} :
                    {rem_ext[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    final_val = '0;
    case (funct3_q)
      FUNCT3_MUL:    final_val = b_zero_q ? '0 : prod_fix[WIDTH-1:0];
      FUNCT3_MULH,
      FUNCT3_MULHSU,
      FUNCT3_MULHU:  final_val = b_zero_q ? '0 : prod_fix[2*WIDTH-1:WIDTH];
      FUNCT3_DIV,
      FUNCT3_DIVU:   final_val = b_zero_q ? '1 : (ovf_q ? SMIN : quo_fix);
      FUNCT3_REM,
      FUNCT3_REMU:   final_val = b_zero_q ? a_raw_q : (ovf_q ? '0 : rem_fix);
      default:       final_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      funct3_q  <= '0;
      a_raw_q   <= '0;
      b_mag_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      ovf_q     <= 1'b0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            funct3_q  <= funct3;
            a_raw_q   <= op_a;
            b_mag_q   <= b_mag;
            neg_res_q <= neg_result;
            neg_rem_q <= neg_rem;
            b_zero_q  <= b_zero;
            ovf_q     <= ovf;
            prod_q    <= {{WIDTH{1'b0}}, a_mag};
            cnt_q     <= '0;
          end
        end
        ST_CALC: begin
          prod_q <= funct3_q[2] ? div_next : mul_next;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        ST_DONE: result_q <= final_val;
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = (state_q == ST_DONE) ? final_val : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops
// against an arithmetic reference model, start-while-busy and mid-op reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      FUNCT3_MUL:    begin p = sa * sb; return p[31:0]; end
      FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
      FUNCT3_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      FUNCT3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      FUNCT3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      FUNCT3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      FUNCT3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0) return 1;
    if ((f3 == FUNCT3_DIV || f3 == FUNCT3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 33;
  endfunction

  // Launch one op and wait for done; cycle 1 is the first cycle after acceptance.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t v[14];
    logic [31:0] res;
    int lat;
    bit bok;
    v[0]  = '{FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1]  = '{FUNCT3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[2]  = '{FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[4]  = '{FUNCT3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[5]  = '{FUNCT3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    v[6]  = '{FUNCT3_DIVU,   32'd100,       32'd7,         32'd14};
    v[7]  = '{FUNCT3_REMU,   32'd100,       32'd7,         32'd2};
    v[8]  = '{FUNCT3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[9]  = '{FUNCT3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    v[10] = '{FUNCT3_DIVU,   32'h1234,      32'h0,         32'hFFFF_FFFF};
    v[11] = '{FUNCT3_REMU,   32'h1234,      32'h0,         32'h1234};
    v[12] = '{FUNCT3_REM,    32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB};
    v[13] = '{FUNCT3_MULH,   32'hDEAD_BEEF, 32'h0,         32'h0};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, res, lat, bok);
      checks++; if (res !== v[i].exp) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, v[i].exp); end
      checks++; if (lat != exp_lat(v[i].f3, v[i].a, v[i].b)) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat(v[i].f3, v[i].a, v[i].b)); end
      checks++; if (!bok) begin failures++; $display("FAIL dir%0d_busy got=low exp=high while op in flight", i); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dir%0d_after got done=%b busy=%b exp 0 0", i, done, busy); end
      checks++; if (result !== v[i].exp) begin failures++; $display("FAIL dir%0d_hold got=%h exp=%h", i, result, v[i].exp); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a, b, res;
    int lat;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = $urandom_range(2, 300);
        default: b = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(f3, a, b, res, lat, bok);
      checks++; if (res !== ref_model(f3, a, b)) begin failures++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h got=%h exp=%h", i, f3, a, b, res, ref_model(f3, a, b)); end
      checks++; if (lat != exp_lat(f3, a, b)) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat(f3, a, b)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3;
    logic [31:0] a, b, res;
    int lat;
    bit bok;
    for (int i = 0; i < 6; i++) begin
      f3 = 3'(i + 2);
      a  = $urandom;
      b  = $urandom | 32'h1;
      run_op(f3, a, b, res, lat, bok);
      checks++; if (res !== ref_model(f3, a, b) || lat != 33 || !bok) begin
        failures++; $display("FAIL b2b%0d got res=%h lat=%0d busy_ok=%0d exp res=%h lat=33 busy_ok=1", i, res, lat, bok, ref_model(f3, a, b));
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] exp;
    int lat;
    exp = ref_model(FUNCT3_MUL, 32'h0001_2345, 32'hFFFF_0010);
    @(negedge clk);
    funct3 = FUNCT3_MUL; op_a = 32'h0001_2345; op_b = 32'hFFFF_0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 10) begin
        funct3 = FUNCT3_DIVU; op_a = 32'd99; op_b = 32'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++; if (result !== exp) begin failures++; $display("FAIL ignore_result got=%h exp=%h", result, exp); end
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got busy=%b done=%b exp 0 0", busy, done); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, dones;
    bit bok;
    run_op(FUNCT3_DIVU, 32'd100, 32'd7, res, lat, bok);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL rstmid_pre got=%h exp=0000000e", res); end
    @(negedge clk);
    funct3 = FUNCT3_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", dones); end
    run_op(FUNCT3_REM, 32'hFFFF_FF00, 32'd7, res, lat, bok);
    checks++; if (res !== ref_model(FUNCT3_REM, 32'hFFFF_FF00, 32'd7) || lat != 33) begin
      failures++; $display("FAIL rstmid_after got=%h lat=%0d exp=%h lat=33", res, lat, ref_model(FUNCT3_REM, 32'hFFFF_FF00, 32'd7));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
